// File: rtl/memory_arbitrator_pkg.sv
// Shared definitions between the EP2 packet router and the memory arbitrator:
// state encoding, header layout and default sizing.
package memory_arbitrator_pkg;

  localparam int unsigned DEF_NUM_PORTS   = 4;
  localparam int unsigned DEF_COUNT_WIDTH = 32;
  localparam int unsigned DEF_MAX_LEN     = 2048;

  // Byte offsets of the header fields within an EP2 packet
  localparam int unsigned HDR_OFF_PORT   = 0;
  localparam int unsigned HDR_OFF_LEN_HI = 1;
  localparam int unsigned HDR_OFF_LEN_LO = 2;
  localparam int unsigned HDR_BYTES      = 3;

  typedef enum logic [2:0] {
    ST_HDR_PORT   = 3'd0,
    ST_HDR_LEN_HI = 3'd1,
    ST_HDR_LEN_LO = 3'd2,
    ST_PAYLOAD    = 3'd3,
    ST_DISCARD    = 3'd4
  } rtr_state_e;

endpackage

// File: rtl/ep2_packet_router.sv
// Parses the EP2 byte stream into {port, len_hi, len_lo, payload} packets and steers
// payload bytes into per-port write FIFOs, keeping per-port byte and packet/error counts.
module ep2_packet_router
  import memory_arbitrator_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = DEF_NUM_PORTS,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int unsigned MAX_LEN     = DEF_MAX_LEN
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       ep2_data,
  input  logic                             ep2_valid,
  output logic                             ep2_ready,
  output logic [7:0]                       fifo_write_data,
  output logic [NUM_PORTS-1:0]             fifo_writes,
  input  logic [NUM_PORTS-1:0]             fifo_fulls,
  output logic [NUM_PORTS*COUNT_WIDTH-1:0] byte_counts,
  output logic [15:0]                      packet_count,
  output logic [15:0]                      error_count,
  output logic                             busy
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  rtr_state_e        state_q, state_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic              bad_q, bad_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       rem_q, rem_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic        in_payload_c;
  logic        port_full_c;
  logic        accept_c;
  logic [15:0] len_c;

  // Ready and write strobes are combinational so a full FIFO stalls with no bubble
  assign in_payload_c    = (state_q == ST_PAYLOAD);
  assign port_full_c     = fifo_fulls[port_q];
  assign ep2_ready       = reset & (in_payload_c ? ~port_full_c : 1'b1);
  assign accept_c        = ep2_valid & ep2_ready;
  assign fifo_write_data = reset ? ep2_data : 8'h00;
  assign len_c           = {len_hi_q, ep2_data};

  always_comb begin
    fifo_writes = '0;
    if (reset && in_payload_c && ep2_valid && !port_full_c) begin
      fifo_writes[port_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HDR_PORT;
      port_q    <= '0;
      bad_q     <= 1'b0;
      len_hi_q  <= 8'h00;
      rem_q     <= 16'h0000;
      pkt_cnt_q <= 16'h0000;
      err_cnt_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      bad_q     <= bad_d;
      len_hi_q  <= len_hi_d;
      rem_q     <= rem_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    bad_d     = bad_q;
    len_hi_d  = len_hi_q;
    rem_d     = rem_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept_c) begin
      unique case (state_q)
        ST_HDR_PORT: begin
          port_d  = PORT_W'(ep2_data);
          bad_d   = (32'(ep2_data) >= NUM_PORTS);
          state_d = ST_HDR_LEN_HI;
        end
        ST_HDR_LEN_HI: begin
          len_hi_d = ep2_data;
          state_d  = ST_HDR_LEN_LO;
        end
        ST_HDR_LEN_LO: begin
          if (len_c == 16'h0000) begin
            state_d = ST_HDR_PORT;
            if (bad_q) err_cnt_d = err_cnt_q + 16'd1;
            else       pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else if (bad_q || (32'(len_c) > MAX_LEN)) begin
            state_d = ST_DISCARD;
            rem_d   = len_c;
          end else begin
            state_d = ST_PAYLOAD;
            rem_d   = len_c;
          end
        end
        ST_PAYLOAD, ST_DISCARD: begin
          // Last byte closes the packet on the same edge it is accepted
          if (rem_q == 16'd1) begin
            state_d = ST_HDR_PORT;
            if (state_q == ST_PAYLOAD) pkt_cnt_d = pkt_cnt_q + 16'd1;
            else                       err_cnt_d = err_cnt_q + 16'd1;
          end
          rem_d = rem_q - 16'd1;
        end
        default: state_d = ST_HDR_PORT;
      endcase
    end
  end

  // Per-port byte counters, wrapping silently
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    logic [COUNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)              cnt_q <= '0;
      else if (fifo_writes[i]) cnt_q <= cnt_q + COUNT_WIDTH'(1);
    end
    assign byte_counts[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
  end

  assign packet_count = pkt_cnt_q;
  assign error_count  = err_cnt_q;
  assign busy         = (state_q != ST_HDR_PORT);

endmodule

// File: tb/tb_ep2_packet_router.sv
// Directed bench for ep2_packet_router: expected FIFO writes go into a scoreboard queue
// that a negedge monitor drains; counters and handshake are checked inline.
module tb_ep2_packet_router;

  localparam int unsigned NP = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned NW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        ep2_data;
  logic              ep2_valid;
  logic              ep2_ready;
  logic [7:0]        fifo_write_data;
  logic [NP-1:0]     fifo_writes;
  logic [NP-1:0]     fifo_fulls;
  logic [NP*CW-1:0]  byte_counts;
  logic [15:0]       packet_count;
  logic [15:0]       error_count;
  logic              busy;

  logic              nw_ready;
  logic [7:0]        nw_wdata;
  logic [NP-1:0]     nw_writes;
  logic [NP*NW-1:0]  nw_counts;
  logic [15:0]       nw_pkt;
  logic [15:0]       nw_err;
  logic              nw_busy;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ep2_packet_router u_dut (
    .clk(clk), .reset(reset), .ep2_data(ep2_data), .ep2_valid(ep2_valid),
    .ep2_ready(ep2_ready), .fifo_write_data(fifo_write_data), .fifo_writes(fifo_writes),
    .fifo_fulls(fifo_fulls), .byte_counts(byte_counts), .packet_count(packet_count),
    .error_count(error_count), .busy(busy)
  );

  // Narrow-counter instance exercises the byte-count wrap boundary cheaply
  ep2_packet_router #(.COUNT_WIDTH(NW)) u_dut_nw (
    .clk(clk), .reset(reset), .ep2_data(ep2_data), .ep2_valid(ep2_valid),
    .ep2_ready(nw_ready), .fifo_write_data(nw_wdata), .fifo_writes(nw_writes),
    .fifo_fulls(fifo_fulls), .byte_counts(nw_counts), .packet_count(nw_pkt),
    .error_count(nw_err), .busy(nw_busy)
  );

  function automatic logic [31:0] bc(input int i);
    return byte_counts[i*CW +: CW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [7:0] port, input logic [7:0] data);
    exp_q.push_back({port, data});
  endtask

  // Present one byte and hold it until accepted; optionally require immediate ready
  task automatic send_byte(input logic [7:0] b, input bit must_ready = 1'b0);
    int t;
    t = 0;
    ep2_data  = b;
    ep2_valid = 1'b1;
    @(negedge clk);
    if (must_ready) chk("ready_immediate", 32'(ep2_ready), 32'd1);
    while (!ep2_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ep2_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: byte %h never accepted, ready %b expected 1", b, ep2_ready);
    end else begin
      @(posedge clk);
    end
    #1;
    ep2_valid = 1'b0;
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (fifo_writes != '0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: strobes %b data %h, expected none", fifo_writes, fifo_write_data);
      end else begin
        logic [15:0] e;
        logic [NP-1:0] oh;
        e  = exp_q.pop_front();
        oh = NP'(1) << e[15:8];
        if (fifo_writes !== oh || fifo_write_data !== e[7:0] || (fifo_writes & fifo_fulls) != '0) begin
          n_err++;
          $display("FAIL fifo_write: strobes %b data %h, expected strobes %b data %h",
                   fifo_writes, fifo_write_data, oh, e[7:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    ep2_data   = 8'h00;
    ep2_valid  = 1'b0;
    fifo_fulls = '0;
    #12;
    // Reset state
    chk("rst_ready", 32'(ep2_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_writes", 32'(fifo_writes), 32'd0);
    chk("rst_pkt", 32'(packet_count), 32'd0);
    chk("rst_err", 32'(error_count), 32'd0);
    chk("rst_bc1", bc(1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // T1: three payload bytes to port 1
    expect_wr(8'd1, 8'hAA); expect_wr(8'd1, 8'hBB); expect_wr(8'd1, 8'hCC);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    chk("t1_bc1", bc(1), 32'd3);
    chk("t1_pkt", 32'(packet_count), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // T2: bad port discarded, then a good packet to port 0
    foreach (exp_q[i]) ;
    send_byte(8'h07, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    chk("t2_err", 32'(error_count), 32'd1);
    chk("t2_pkt", 32'(packet_count), 32'd1);
    expect_wr(8'd0, 8'h5A);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h5A);
    chk("t2_bc0", bc(0), 32'd1);
    chk("t2_pkt2", 32'(packet_count), 32'd2);

    // T3: port 2 stalls for 5 cycles after its second payload byte
    expect_wr(8'd2, 8'h01); expect_wr(8'd2, 8'h02); expect_wr(8'd2, 8'h03); expect_wr(8'd2, 8'h04);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    fifo_fulls = 4'b0100;
    ep2_data   = 8'h03;
    ep2_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(ep2_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("t3_bc2_stalled", bc(2), 32'd2);
    fifo_fulls = '0;
    send_byte(8'h03); send_byte(8'h04);
    chk("t3_bc2", bc(2), 32'd4);
    chk("t3_pkt", 32'(packet_count), 32'd3);

    // T4: oversize length 0x0801 on port 0 is discarded in full
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h01);
    for (int k = 0; k < 2049; k++) begin
      send_byte(8'(k));
      if (k == 2047) chk("t4_busy_last", 32'(busy), 32'd1);
    end
    chk("t4_err", 32'(error_count), 32'd2);
    chk("t4_bc0", bc(0), 32'd1);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // T5: zero-length packet to port 3, then narrow counter wraps at 16 writes
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    chk("t5_pkt", 32'(packet_count), 32'd4);
    chk("t5_bc3_zero", bc(3), 32'd0);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10);
    for (int k = 0; k < 16; k++) begin
      expect_wr(8'd3, 8'(8'h40 + k));
      send_byte(8'(8'h40 + k));
      if (k == 14) chk("t5_nw_max", 32'(nw_counts[3*NW +: NW]), 32'hF);
    end
    chk("t5_nw_wrap", 32'(nw_counts[3*NW +: NW]), 32'h0);
    chk("t5_bc3", bc(3), 32'd16);
    chk("t5_pkt2", 32'(packet_count), 32'd5);

    // T6: asynchronous reset in the middle of a payload
    expect_wr(8'd1, 8'hD0); expect_wr(8'd1, 8'hD1);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hD0); send_byte(8'hD1);
    ep2_data  = 8'h77;
    ep2_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("t6_ready", 32'(ep2_ready), 32'd0);
    chk("t6_writes", 32'(fifo_writes), 32'd0);
    chk("t6_wdata", 32'(fifo_write_data), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pkt", 32'(packet_count), 32'd0);
    chk("t6_bc1", bc(1), 32'd0);
    repeat (2) @(posedge clk);
    ep2_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    expect_wr(8'd2, 8'h9C);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h9C);
    chk("t6_bc2", bc(2), 32'd1);
    chk("t6_pkt_after", 32'(packet_count), 32'd1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
